mem_bus_responder: RTL and testbench

Memory-side responder for the shared request/response bus used by the instruction/data caches and TLB page walkers. It accepts line-sized read and write requests, acknowledges them, and serves them from an internal word-addressed backing array. Read data returns as a tagged 8-beat burst with per-beat acknowledgement. It sits on the far end of the arbitrated bus and is the simulation memory for the core.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/mem_bus_responder_mem_array.sv | 25 ++
 rtl/mem_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared request/response bus definitions used by the memory responder and the
// cache / TLB initiators: tag field layout, tag type codes, line geometry.
package bus_pkg;

  localparam int TAG_WRITE_BIT = 12;
  localparam int TAG_TYPE_MSB  = 11;
  localparam int TAG_TYPE_LSB  = 8;
  localparam int TAG_ID_MSB    = 7;
  localparam int TAG_ID_LSB    = 0;

  localparam logic [3:0] TAG_TYPE_MEMORY = 4'h0;
  localparam logic [3:0] TAG_TYPE_MMIO   = 4'h1;

  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = $clog2(LINE_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_WAIT,
    ST_RD_RESP
  } resp_state_e;

  function automatic logic tag_is_write(input logic [TAG_WRITE_BIT:0] tag);
    return tag[TAG_WRITE_BIT];
  endfunction

endpackage

// File: rtl/mem_bus_responder_mem_array.sv
// Backing store for the responder: one shared address, synchronous write,
// asynchronous read. Separate module so a bench can preload it hierarchically.
module mem_array #(
  parameter int WORDS  = 4096,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // NOTE: the array has no reset branch; clearing it would need a per-word
  // write sequence, and its contents are simply undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: acks line reads/writes, stores write beats and
// returns read lines as a tagged LINE_BEATS-beat burst with per-beat ack.
module mem_bus_responder
  import bus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] in_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  in_bus_reqtag,
  output logic                      out_bus_reqack,
  output logic                      out_bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] out_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  out_bus_resptag,
  input  logic                      in_bus_respack,
  output logic                      out_busy
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef logic [IDX_W-1:0] idx_t;

  resp_state_e               state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  idx_t                      base_q, base_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;
  logic                      busy_q, busy_d;

  logic                      mem_we;
  logic [BEAT_W-1:0]         rd_beat;
  idx_t                      mem_addr;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;

  // While bursting, look one beat ahead so resp can be registered with no bubble.
  assign rd_beat  = (state_q == ST_RD_RESP) ? beat_q + BEAT_W'(1) : beat_q;
  assign mem_addr = base_q | {{(IDX_W - BEAT_W){1'b0}}, rd_beat};

  mem_array #(
    .WORDS (MEM_WORDS),
    .WIDTH (BUS_DATA_WIDTH),
    .ADDR_W(IDX_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(in_bus_req),
    .rdata(mem_rdata)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    reqack_d  = 1'b0;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    mem_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_bus_reqcyc) begin
          base_d    = in_bus_req[3 +: IDX_W] & ~idx_t'(LINE_BEATS - 1);
          resptag_d = in_bus_reqtag;
          reqack_d  = 1'b1;
          beat_d    = '0;
          if (tag_is_write(in_bus_reqtag[TAG_WRITE_BIT:0])) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end
        end
      end
      ST_WR_DATA: begin
        if (in_bus_reqcyc) begin
          mem_we   = !reset;
          reqack_d = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = ST_RD_RESP;
          respcyc_d = 1'b1;
          resp_d    = mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_RESP: begin
        if (in_bus_respack) begin
          if (beat_q == LAST_BEAT) begin
            state_d   = ST_IDLE;
            respcyc_d = 1'b0;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            resp_d = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
      busy_q    <= busy_d;
    end
  end

  assign out_bus_reqack  = reqack_q;
  assign out_bus_respcyc = respcyc_q;
  assign out_bus_resp    = resp_q;
  assign out_bus_resptag = resptag_q;
  assign out_busy        = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a write-side model memory feeds a queue
// of expected read beats that is drained as the responder presents them.
module tb_mem_bus_responder;

  localparam int DW  = 64;
  localparam int TW  = 13;
  localparam int MW  = 4096;
  localparam int RL  = 4;
  localparam int LB  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_bus_reqcyc = 1'b0;
  logic [DW-1:0] in_bus_req = '0;
  logic [TW-1:0] in_bus_reqtag = '0;
  logic          out_bus_reqack;
  logic          out_bus_respcyc;
  logic [DW-1:0] out_bus_resp;
  logic [TW-1:0] out_bus_resptag;
  logic          in_bus_respack = 1'b0;
  logic          out_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_q [$];

  mem_bus_responder #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .MEM_WORDS     (MW),
    .READ_LATENCY  (RL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_bus_reqcyc  (in_bus_reqcyc),
    .in_bus_req     (in_bus_req),
    .in_bus_reqtag  (in_bus_reqtag),
    .out_bus_reqack (out_bus_reqack),
    .out_bus_respcyc(out_bus_respcyc),
    .out_bus_resp   (out_bus_resp),
    .out_bus_resptag(out_bus_resptag),
    .in_bus_respack (in_bus_respack),
    .out_busy       (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  function automatic int line_base(input logic [63:0] addr);
    return int'((addr >> 3) & 64'(MW - 1) & ~64'(LB - 1));
  endfunction

  // Present a request (or keep presenting it) until acked; inputs change on negedge.
  task automatic send_req(input logic [63:0] addr, input logic [TW-1:0] rtag);
    int w = 0;
    in_bus_reqcyc = 1'b1;
    in_bus_req    = addr;
    in_bus_reqtag = rtag;
    do begin
      @(negedge clk);
      w++;
    end while (!out_bus_reqack && w < 50);
    check("req_ack_wait", 64'(w), 64'd1);
    check("req_busy", 64'(out_busy), 64'd1);
    in_bus_reqcyc = 1'b0;
    in_bus_req    = '0;
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [TW-1:0] rtag,
                            input logic [63:0] data0, input logic [63:0] step,
                            input int gap_after, input int gap_len);
    int base;
    logic [63:0] d;
    send_req(addr, rtag);
    base = line_base(addr);
    for (int i = 0; i < LB; i++) begin
      d = data0 + 64'(i) * step;
      in_bus_reqcyc = 1'b1;
      in_bus_req    = d;
      @(negedge clk);
      check("wr_beat_ack", 64'(out_bus_reqack), 64'd1);
      check("wr_busy", 64'(out_busy), (i < LB - 1) ? 64'd1 : 64'd0);
      model_mem[base + i] = d;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          in_bus_reqcyc = 1'b0;
          in_bus_req    = 64'hDEAD_0000_0000_0000 | 64'(g);
          @(negedge clk);
          check("wr_gap_ack", 64'(out_bus_reqack), 64'd0);
          check("wr_gap_busy", 64'(out_busy), 64'd1);
        end
      end
    end
    in_bus_reqcyc = 1'b0;
    in_bus_req    = '0;
  endtask

  // Collect one read burst after send_req returned on the ack cycle.
  task automatic recv_burst(input logic [63:0] addr, input logic [TW-1:0] rtag,
                            input bit toggle, input bit check_lat, input int abort_beat,
                            input bit pend, input logic [63:0] paddr, input logic [TW-1:0] ptag);
    int base;
    int k = 1, first_k = -1, cyc = 0, stalls = 0, got = 0;
    bit last_ack = 1'b1, done = 1'b0, ack;
    logic [DW-1:0] prev_resp = '0, expv;
    base = line_base(addr);
    for (int i = 0; i < LB; i++) exp_q.push_back(model_mem[base + i]);
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (out_bus_respcyc) begin
        if (first_k < 0) begin
          first_k = k;
          if (pend) begin
            in_bus_reqcyc = 1'b1;
            in_bus_req    = paddr;
            in_bus_reqtag = ptag;
          end
        end else if (!last_ack) begin
          check("rd_hold_data", out_bus_resp, prev_resp);
        end
        cyc++;
        check("rd_tag", 64'(out_bus_resptag), 64'(rtag));
        if (pend) check("rd_busy_no_ack", 64'(out_bus_reqack), 64'd0);
        if (got == abort_beat) begin
          reset          = 1'b1;
          in_bus_respack = 1'b0;
          @(negedge clk);
          check("rst_respcyc", 64'(out_bus_respcyc), 64'd0);
          check("rst_busy", 64'(out_busy), 64'd0);
          check("rst_reqack", 64'(out_bus_reqack), 64'd0);
          check("rst_resp", out_bus_resp, 64'd0);
          reset = 1'b0;
          exp_q.delete();
          return;
        end
        ack = toggle ? (cyc % 2 == 1) : 1'b1;
        in_bus_respack = ack;
        if (!ack) stalls++;
        if (ack) begin
          expv = exp_q.pop_front();
          check("rd_data", out_bus_resp, expv);
          got++;
        end
        last_ack  = ack;
        prev_resp = out_bus_resp;
      end else begin
        in_bus_respack = 1'b0;
        if (first_k >= 0) done = 1'b1;
      end
    end
    check("rd_burst_done", 64'(done), 64'd1);
    check("rd_beats", 64'(got), 64'(LB));
    check("rd_cycles", 64'(cyc), 64'(LB + stalls));
    check("rd_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rd_idle_after", 64'(out_busy), pend ? 64'd0 : 64'd0);
    if (check_lat) check("rd_latency", 64'(first_k), 64'(1 + RL));
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_reqack", 64'(out_bus_reqack), 64'd0);
    check("reset_respcyc", 64'(out_bus_respcyc), 64'd0);
    check("reset_resp", out_bus_resp, 64'd0);
    check("reset_resptag", 64'(out_bus_resptag), 64'd0);
    check("reset_busy", 64'(out_busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic line write then zero-stall read with latency check.
    write_line(64'h40, 13'h1005, 64'h1000, 64'd1, -1, 0);
    send_req(64'h40, 13'h0007);
    recv_burst(64'h40, 13'h0007, 1'b0, 1'b1, -1, 1'b0, '0, '0);

    // Write with a stall gap, read back with toggling respack.
    write_line(64'h100, 13'h1102, 64'hBEEF_0000, 64'h11, 2, 3);
    send_req(64'h100, 13'h0103);
    recv_burst(64'h100, 13'h0103, 1'b1, 1'b0, -1, 1'b0, '0, '0);

    // Second request held during a burst; accepted only once back in IDLE.
    send_req(64'h40, 13'h0008);
    recv_burst(64'h40, 13'h0008, 1'b0, 1'b1, -1, 1'b1, 64'h100, 13'h0009);
    send_req(64'h100, 13'h0009);
    recv_burst(64'h100, 13'h0009, 1'b0, 1'b1, -1, 1'b0, '0, '0);

    // Aliasing beyond the array and an unaligned byte address in the same line.
    send_req(64'h40 + 64'(MW) * 8, 13'h000A);
    recv_burst(64'h40, 13'h000A, 1'b0, 1'b1, -1, 1'b0, '0, '0);
    send_req(64'h47, 13'h000B);
    recv_burst(64'h40, 13'h000B, 1'b0, 1'b1, -1, 1'b0, '0, '0);

    // Reset at read beat 3, then a full read of the same line.
    send_req(64'h100, 13'h000C);
    recv_burst(64'h100, 13'h000C, 1'b0, 1'b0, 3, 1'b0, '0, '0);
    @(negedge clk);
    send_req(64'h100, 13'h000D);
    recv_burst(64'h100, 13'h000D, 1'b0, 1'b1, -1, 1'b0, '0, '0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
